// File: rtl/saber_matvec_sched_if.sv
// Bundle of the scheduler's control, multiplier and result-stream signals.
// master = scheduler side, slave = environment (top FSM, multiplier, consumer).
interface saber_matvec_sched_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              busy;
  logic              done;
  logic              pm_rst;
  logic              pm_acc_clear;
  logic              pm_read;
  logic              pm_done;
  logic [63:0]       pm_coeff4x;
  logic [ADDR_W-1:0] pol_base_addr;
  logic [ADDR_W-1:0] s_base_addr;
  logic [63:0]       res_data;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_row;
  logic [5:0]        res_idx;

  modport master (
    input  start, pm_done, pm_coeff4x, res_ready,
    output busy, done, pm_rst, pm_acc_clear, pm_read,
           pol_base_addr, s_base_addr, res_data, res_valid, res_row, res_idx
  );

  modport slave (
    output start, pm_done, pm_coeff4x, res_ready,
    input  busy, done, pm_rst, pm_acc_clear, pm_read,
           pol_base_addr, s_base_addr, res_data, res_valid, res_row, res_idx
  );
endinterface

// File: rtl/saber_matvec_sched.sv
// Saber matrix-vector product sequencer: walks the multiplier through
// b[i] = sum_j A[i][j]*s[j], keeping the accumulator across j and
// streaming each finished row out word by word over valid/ready.
module saber_matvec_sched #(
  parameter int L         = 3,
  parameter int POL_WORDS = 52,
  parameter int S_WORDS   = 16,
  parameter int RES_WORDS = 64,
  parameter int ADDR_W    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  saber_matvec_sched_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    REARM = 3'd3,
    READ  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [1:0] IDX_LAST  = 2'(L - 1);
  localparam logic [5:0] WORD_LAST = 6'(RES_WORDS - 1);

  state_t     state_r;
  logic [1:0] row_r;
  logic [1:0] col_r;
  // First RUN cycle after a multiplier restart: pm_done may still show the
  // previous product, so it is not trusted in that cycle.
  logic       stale_r;

  function automatic logic [ADDR_W-1:0] pol_base(input logic [1:0] i, input logic [1:0] j);
    return ADDR_W'((int'(i) * L + int'(j)) * POL_WORDS);
  endfunction

  function automatic logic [ADDR_W-1:0] s_base(input logic [1:0] j);
    return ADDR_W'(int'(j) * S_WORDS);
  endfunction

  // The result word is the multiplier output, passed straight through.
  assign bus.res_data = bus.pm_coeff4x;

  // Sequencing FSM with all control outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= IDLE;
      row_r             <= 2'd0;
      col_r             <= 2'd0;
      stale_r           <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.pm_rst        <= 1'b1;
      bus.pm_acc_clear  <= 1'b1;
      bus.pm_read       <= 1'b0;
      bus.res_valid     <= 1'b0;
      bus.pol_base_addr <= '0;
      bus.s_base_addr   <= '0;
      bus.res_row       <= 2'd0;
      bus.res_idx       <= 6'd0;
    end else begin
      bus.done    <= 1'b0;
      bus.pm_read <= 1'b0;
      case (state_r)
        IDLE: begin
          bus.pm_rst       <= 1'b1;
          bus.pm_acc_clear <= 1'b1;
          if (bus.start) begin
            state_r           <= CLEAR;
            row_r             <= 2'd0;
            col_r             <= 2'd0;
            bus.busy          <= 1'b1;
            bus.pol_base_addr <= pol_base(2'd0, 2'd0);
            bus.s_base_addr   <= s_base(2'd0);
          end else begin
            state_r <= IDLE;
          end
        end
        CLEAR: begin
          bus.pm_rst       <= 1'b0;
          bus.pm_acc_clear <= 1'b0;
          stale_r          <= 1'b1;
          state_r          <= RUN;
        end
        RUN: begin
          if (stale_r) begin
            stale_r <= 1'b0;
          end else if (bus.pm_done) begin
            if (col_r != IDX_LAST) begin
              // Next column: restart the multiplier but keep its accumulator.
              col_r             <= col_r + 2'd1;
              state_r           <= REARM;
              bus.pm_rst        <= 1'b1;
              bus.pol_base_addr <= pol_base(row_r, col_r + 2'd1);
              bus.s_base_addr   <= s_base(col_r + 2'd1);
            end else begin
              col_r         <= 2'd0;
              state_r       <= READ;
              bus.res_valid <= 1'b1;
              bus.res_idx   <= 6'd0;
              bus.res_row   <= row_r;
            end
          end else begin
            state_r <= RUN;
          end
        end
        REARM: begin
          bus.pm_rst <= 1'b0;
          stale_r    <= 1'b1;
          state_r    <= RUN;
        end
        READ: begin
          if (!bus.res_valid) begin
            // Settle cycle after pm_read is over: offer the next word.
            bus.res_valid <= 1'b1;
          end else if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.pm_read   <= 1'b1;
            bus.res_idx   <= bus.res_idx + 6'd1;
            if (bus.res_idx == WORD_LAST) begin
              if (row_r != IDX_LAST) begin
                row_r             <= row_r + 2'd1;
                state_r           <= CLEAR;
                bus.pm_rst        <= 1'b1;
                bus.pm_acc_clear  <= 1'b1;
                bus.pol_base_addr <= pol_base(row_r + 2'd1, 2'd0);
                bus.s_base_addr   <= s_base(2'd0);
              end else begin
                state_r  <= DONE;
                bus.done <= 1'b1;
              end
            end else begin
              state_r <= READ;
            end
          end else begin
            state_r <= READ;
          end
        end
        DONE: begin
          bus.busy         <= 1'b0;
          bus.pm_rst       <= 1'b1;
          bus.pm_acc_clear <= 1'b1;
          state_r          <= IDLE;
        end
        default: begin
          state_r          <= IDLE;
          bus.busy         <= 1'b0;
          bus.pm_rst       <= 1'b1;
          bus.pm_acc_clear <= 1'b1;
          bus.res_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_saber_matvec_sched.sv
// Self-checking bench for saber_matvec_sched: behavioural multiplier model,
// result consumer and monitor, plus directed product runs.
module tb_saber_matvec_sched;

  logic clk;
  logic rst;

  saber_matvec_sched_if #(.ADDR_W(10)) bus ();

  saber_matvec_sched #(
    .L(3), .POL_WORDS(52), .S_WORDS(16), .RES_WORDS(64), .ADDR_W(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Bench control
  bit hold_done   = 1'b0;
  bit toggle_rdy  = 1'b0;
  int epoch       = 0;

  // Multiplier model state
  int         mul_cnt  = 0;
  logic [5:0] mul_word = 6'd0;

  // Monitor state
  int         seen_epoch   = -1;
  logic       prev_pm_rst  = 1'b1;
  int         run_count    = 0;
  bit         in_run       = 1'b0;
  int         run_len      = 0;
  int         hs_count     = 0;
  int         read_count   = 0;
  int         done_count   = 0;
  int         clear_cycles = 0;
  int         rearm_cycles = 0;
  logic [5:0] exp_idx      = 6'd0;
  logic [1:0] exp_row      = 2'd0;
  logic [63:0] exp_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier/consumer model driven on the falling edge, then monitor at +1.
  always @(negedge clk) begin
    if (bus.pm_rst) begin
      mul_cnt  = 0;
      mul_word = 6'd0;
    end else begin
      if (mul_cnt < 20) mul_cnt++;
      if (bus.pm_read) mul_word = mul_word + 6'd1;
    end
    bus.pm_done    = hold_done ? 1'b1 : (mul_cnt >= 20);
    bus.pm_coeff4x = {32'hC0FFEE00, 26'd0, mul_word};
    bus.res_ready  = toggle_rdy ? ~bus.res_ready : 1'b1;
    #1;
    if (epoch != seen_epoch) begin
      seen_epoch   = epoch;
      run_count    = 0;
      in_run       = 1'b0;
      run_len      = 0;
      hs_count     = 0;
      read_count   = 0;
      done_count   = 0;
      clear_cycles = 0;
      rearm_cycles = 0;
      exp_idx      = 6'd0;
      exp_row      = 2'd0;
    end
    if (!rst) begin
      if (bus.busy && prev_pm_rst && !bus.pm_rst) begin
        if (run_count < 9) begin
          check("pol_base", 64'(bus.pol_base_addr), 64'(run_count * 52));
          check("s_base", 64'(bus.s_base_addr), 64'((run_count % 3) * 16));
        end
        run_count++;
        in_run  = 1'b1;
        run_len = 0;
      end
      if (in_run) begin
        if (bus.pm_rst || bus.res_valid) begin
          in_run = 1'b0;
          if (hold_done) check("run_len", 64'(run_len), 64'd2);
        end else begin
          run_len++;
        end
      end
      if (bus.busy && bus.pm_rst && bus.pm_acc_clear) clear_cycles++;
      if (bus.busy && bus.pm_rst && !bus.pm_acc_clear) rearm_cycles++;
      if (bus.pm_read) read_count++;
      if (bus.done) done_count++;
      if (bus.res_valid) begin
        exp_data = {32'hC0FFEE00, 26'd0, exp_idx};
        check("res_idx", 64'(bus.res_idx), 64'(exp_idx));
        check("res_row", 64'(bus.res_row), 64'(exp_row));
        check("res_data", bus.res_data, exp_data);
        if (bus.res_ready) begin
          hs_count++;
          exp_idx = exp_idx + 6'd1;
          if (exp_idx == 6'd0) exp_row = exp_row + 2'd1;
        end
      end
    end
    prev_pm_rst = bus.pm_rst;
  end

  // One full product; optionally pulses start again while row 1 is running.
  task automatic do_product(input bit inject_start);
    bit injected;
    injected = 1'b0;
    epoch++;
    @(negedge clk); #2; bus.start = 1'b1;
    @(negedge clk); #2; bus.start = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk); #2;
      if (inject_start && !injected && run_count >= 4 && !bus.pm_rst) begin
        bus.start = 1'b1;
        @(negedge clk); #2;
        bus.start = 1'b0;
        injected  = 1'b1;
      end
      if (!bus.busy) break;
    end
    check("finish_in_budget", 64'(bus.busy), 64'd0);
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_runs"}, 64'(run_count), 64'd9);
    check({tag, "_handshakes"}, 64'(hs_count), 64'd192);
    check({tag, "_pm_reads"}, 64'(read_count), 64'd192);
    check({tag, "_done_pulses"}, 64'(done_count), 64'd1);
    check({tag, "_clear_cycles"}, 64'(clear_cycles), 64'd3);
    check({tag, "_rearm_cycles"}, 64'(rearm_cycles), 64'd6);
    check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
    check({tag, "_valid_end"}, 64'(bus.res_valid), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    // Reset values
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_pm_rst", 64'(bus.pm_rst), 64'd1);
    check("rst_acc_clear", 64'(bus.pm_acc_clear), 64'd1);
    check("rst_pm_read", 64'(bus.pm_read), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_pol_base", 64'(bus.pol_base_addr), 64'd0);
    check("rst_s_base", 64'(bus.s_base_addr), 64'd0);
    check("rst_res_row", 64'(bus.res_row), 64'd0);
    check("rst_res_idx", 64'(bus.res_idx), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain product with an always-ready consumer
    do_product(1'b0);
    check_counts("basic");

    // Consumer alternates ready every cycle
    toggle_rdy = 1'b1;
    do_product(1'b0);
    check_counts("backpressure");
    toggle_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // Start pulsed while busy must be ignored
    do_product(1'b1);
    check_counts("start_busy");

    // Reset in the middle of row 1, column 2
    epoch++;
    @(negedge clk); #2; bus.start = 1'b1;
    @(negedge clk); #2; bus.start = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk); #2;
      if (run_count >= 6) break;
    end
    check("reached_row1_col2", 64'(run_count), 64'd6);
    repeat (3) @(negedge clk);
    #2;
    check("pre_rst_in_run", 64'(bus.pm_rst), 64'd0);
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_pm_rst", 64'(bus.pm_rst), 64'd1);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_res_valid", 64'(bus.res_valid), 64'd0);
    check("midrst_pol_base", 64'(bus.pol_base_addr), 64'd0);
    @(negedge clk); #2;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    do_product(1'b0);
    check_counts("after_rst");

    // pm_done stuck high: stale first RUN cycle must be skipped every time
    hold_done = 1'b1;
    do_product(1'b0);
    check_counts("done_held");
    hold_done = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
